// File: rtl/hfrv_resp_pkg.sv
// Shared types and constants for the wait-state responder: FSM states,
// wait-counter width, out-of-range read value and a byte-lane mask helper.
package hfrv_resp_pkg;

    localparam int          CNT_W     = 4;
    localparam logic [31:0] OOR_RDATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } resp_state_e;

    // Expand 4 per-lane write enables into a 32-bit bit mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] we);
        logic [31:0] mask;
        mask = 32'h0000_0000;
        for (int n = 0; n < 4; n++) begin
            mask[8*n +: 8] = {8{we[n]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/resp_mem.sv
// Word array with four byte lanes: synchronous per-lane write, combinational
// read of the addressed word. Contents are intentionally never reset.
module resp_mem
    import hfrv_resp_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk_i,
    input  logic [DEPTH_LOG2-1:0] idx_i,
    input  logic [31:0]           wdata_i,
    input  logic [3:0]            we_i,
    output logic [31:0]           rdata_o
);

    logic [31:0] mem_r [2**DEPTH_LOG2];
    logic [31:0] mask_s;

    assign mask_s  = lane_mask(we_i);
    assign rdata_o = mem_r[idx_i];

    // Merge enabled lanes of the write data into the addressed word.
    always_ff @(posedge clk_i) begin
        if (|we_i) begin
            mem_r[idx_i] <= (mem_r[idx_i] & ~mask_s) | (wdata_i & mask_s);
        end
    end

endmodule

// File: rtl/wait_state_responder.sv
// Memory responder that stalls the CPU for WAIT_CYCLES cycles per access.
// Optional macro WAIT_RESP_OOR_ERR_EN enables out-of-range detection and err_o.
module wait_state_responder
    import hfrv_resp_pkg::*;
#(
    parameter logic [3:0] REGION      = 4'h5,
    parameter int         WAIT_CYCLES = 2,
    parameter int         DEPTH_LOG2  = 8
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic [3:0]  data_w_i,
    output logic [31:0] data_o,
    output logic        stall_o,
    output logic        err_o
);

    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    resp_state_e           state_r;
    logic [CNT_W-1:0]      cnt_r;
    logic                  err_r;
    logic                  hit_s;
    logic                  exec_s;
    logic                  oor_s;
    logic                  rd_s;
    logic                  wr_s;
    logic [3:0]            mem_we_s;
    logic [31:0]           rdata_s;
    logic [DEPTH_LOG2-1:0] idx_s;
    logic                  unused_addr_s;

    assign idx_s = addr_i[DEPTH_LOG2+1:2];

`ifdef WAIT_RESP_OOR_ERR_EN
    assign oor_s         = |addr_i[27:DEPTH_LOG2+2];
    assign unused_addr_s = ^addr_i[1:0];
`else
    assign oor_s         = 1'b0;
    assign unused_addr_s = ^{addr_i[27:DEPTH_LOG2+2], addr_i[1:0]};
`endif

    // Decode hit and the execution cycle. The access fires at the edge ending
    // the last stall cycle, so stall is high exactly WAIT_CYCLES cycles; with
    // WAIT_CYCLES of 0 or 1 that edge is the one ending the hit cycle itself.
    always_comb begin
        hit_s  = (addr_i[31:28] == REGION) && (state_r == IDLE);
        exec_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (hit_s && (WAIT_CYCLES <= 1)) begin
                    exec_s = 1'b1;
                end else begin
                    exec_s = 1'b0;
                end
            end
            WAIT: begin
                if (cnt_r == CNT_W'(1)) begin
                    exec_s = 1'b1;
                end else begin
                    exec_s = 1'b0;
                end
            end
            DONE:    exec_s = 1'b0;
            default: exec_s = 1'b0;
        endcase
        exec_s   = exec_s && rst_n_i;
        rd_s     = exec_s && (data_w_i == 4'b0000);
        wr_s     = exec_s && (data_w_i != 4'b0000) && !oor_s;
        mem_we_s = wr_s ? data_w_i : 4'b0000;
    end

    // Stall is combinational so the CPU is held in the hit cycle itself.
    always_comb begin
        if (!rst_n_i) begin
            stall_o = 1'b0;
        end else if (state_r == WAIT) begin
            stall_o = 1'b1;
        end else begin
            stall_o = hit_s && (WAIT_CYCLES != 0);
        end
    end

    // Control FSM, wait counter, read-data register and sticky error flag.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            data_o  <= 32'h0000_0000;
            err_r   <= 1'b0;
        end else begin
            if (rd_s) begin
                data_o <= oor_s ? OOR_RDATA : rdata_s;
            end
`ifdef WAIT_RESP_OOR_ERR_EN
            if (exec_s && oor_s) begin
                err_r <= 1'b1;
            end
`endif
            case (state_r)
                IDLE: begin
                    if (hit_s && (WAIT_CYCLES == 1)) begin
                        state_r <= DONE;
                    end else if (hit_s && (WAIT_CYCLES > 1)) begin
                        state_r <= WAIT;
                        cnt_r   <= WAIT_LOAD;
                    end
                end
                WAIT: begin
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        state_r <= DONE;
                    end
                end
                DONE: state_r <= IDLE;
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign err_o = err_r;

    resp_mem #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_mem (
        .clk_i  (clk_i),
        .idx_i  (idx_s),
        .wdata_i(data_i),
        .we_i   (mem_we_s),
        .rdata_o(rdata_s)
    );

endmodule

// File: tb/tb_wait_state_responder.sv
// Bench for wait_state_responder: a WAIT_CYCLES=2 instance driven by hand
// sequences and a WAIT_CYCLES=0 instance driven from a vector table.
module tb_wait_state_responder;

`ifdef WAIT_RESP_OOR_ERR_EN
    localparam bit OOR_EN = 1'b1;
`else
    localparam bit OOR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr_a = 32'h0, data_a = 32'h0, dout_a;
    logic [3:0]  we_a = 4'h0;
    logic        stall_a, err_a;
    logic [31:0] addr_b = 32'h0, data_b = 32'h0, dout_b;
    logic [3:0]  we_b = 4'h0;
    logic        stall_b, err_b;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  we;
        logic [31:0] exp_d;
        logic        exp_e;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic        e;
    } exp_t;

    vec_t        vecs[12];
    exp_t        sb_b[$];
    logic [31:0] sb_a[$];

    always #5 clk = ~clk;

    wait_state_responder #(.REGION(4'h5), .WAIT_CYCLES(2), .DEPTH_LOG2(8)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .addr_i(addr_a), .data_i(data_a),
        .data_w_i(we_a), .data_o(dout_a), .stall_o(stall_a), .err_o(err_a)
    );

    wait_state_responder #(.REGION(4'h5), .WAIT_CYCLES(0), .DEPTH_LOG2(8)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .addr_i(addr_b), .data_i(data_b),
        .data_w_i(we_b), .data_o(dout_b), .stall_o(stall_b), .err_o(err_b)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // One access on the W=2 instance: count stall cycles, compare read data in DONE.
    task automatic acc_a(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w,
                         input logic [31:0] exp_rd, input string nm);
        int n;
        logic [31:0] e;
        if (w == 4'h0) sb_a.push_back(exp_rd);
        @(negedge clk);
        addr_a = a; data_a = d; we_a = w;
        n = 0;
        #1;
        while (stall_a === 1'b1 && n < 16) begin
            n++;
            @(negedge clk);
            #1;
        end
        check({nm, "_stall_cycles"}, 32'(n), 32'd2);
        if (w == 4'h0) begin
            e = sb_a.pop_front();
            check({nm, "_rdata"}, dout_a, e);
        end
        @(negedge clk);
        addr_a = 32'h0; we_a = 4'h0;
        #1;
        check({nm, "_idle_stall"}, {31'h0, stall_a}, 32'h0);
    endtask

    initial begin
        exp_t ex;

        vecs[0]  = '{32'h5000_0000, 32'hCAFE_0001, 4'hF,    32'h0000_0000, 1'b0};
        vecs[1]  = '{32'h5000_0004, 32'h1234_5678, 4'hF,    32'h0000_0000, 1'b0};
        vecs[2]  = '{32'h5000_0000, 32'h0000_0000, 4'h0,    32'hCAFE_0001, 1'b0};
        vecs[3]  = '{32'h5000_0004, 32'h0000_0000, 4'h0,    32'h1234_5678, 1'b0};
        vecs[4]  = '{32'h5000_0004, 32'hFFFF_FFFF, 4'b1000, 32'h1234_5678, 1'b0};
        vecs[5]  = '{32'h5000_0004, 32'h0000_0000, 4'h0,    32'hFF34_5678, 1'b0};
        vecs[6]  = '{32'h4000_0004, 32'h0000_0000, 4'h0,    32'hFF34_5678, 1'b0};
        vecs[7]  = '{32'h4000_0000, 32'h0000_0000, 4'hF,    32'hFF34_5678, 1'b0};
        vecs[8]  = '{32'h5000_0000, 32'h0000_0000, 4'h0,    32'hCAFE_0001, 1'b0};
        vecs[9]  = '{32'h5000_1000, 32'h0000_0000, 4'h0,
                     OOR_EN ? 32'hDEAD_BEEF : 32'hCAFE_0001, OOR_EN};
        vecs[10] = '{32'h5000_03FC, 32'h0BAD_F00D, 4'hF,    vecs[9].exp_d, OOR_EN};
        vecs[11] = '{32'h5000_03FC, 32'h0000_0000, 4'h0,    32'h0BAD_F00D, OOR_EN};

        // Reset state.
        #1;
        check("rst_stall_a", {31'h0, stall_a}, 32'h0);
        check("rst_data_a", dout_a, 32'h0);
        check("rst_err_a", {31'h0, err_a}, 32'h0);
        check("rst_data_b", dout_b, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero-wait instance: one vector per cycle, results one edge later.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i > 0) begin
                ex = sb_b.pop_front();
                check($sformatf("vec%0d_data", i - 1), dout_b, ex.d);
                check($sformatf("vec%0d_err", i - 1), {31'h0, err_b}, {31'h0, ex.e});
            end
            addr_b = vecs[i].addr; data_b = vecs[i].data; we_b = vecs[i].we;
            sb_b.push_back('{vecs[i].exp_d, vecs[i].exp_e});
            #1;
            check($sformatf("vec%0d_stall", i), {31'h0, stall_b}, 32'h0);
        end
        @(negedge clk);
        ex = sb_b.pop_front();
        check("vec11_data", dout_b, ex.d);
        check("vec11_err", {31'h0, err_b}, {31'h0, ex.e});
        addr_b = 32'h0; we_b = 4'h0;

        // Two-wait instance: full write, readback, partial-lane write, readback.
        acc_a(32'h5000_0010, 32'h1122_3344, 4'hF, 32'h0, "wr_full");
        acc_a(32'h5000_0010, 32'h0, 4'h0, 32'h1122_3344, "rd_full");
        acc_a(32'h5000_0010, 32'hAABB_CCDD, 4'b0010, 32'h0, "wr_lane1");
        acc_a(32'h5000_0010, 32'h0, 4'h0, 32'h1122_CC44, "rd_lane1");
        acc_a(32'h5000_0020, 32'h5555_5555, 4'hF, 32'h0, "wr_prior");

        // Reset during WAIT aborts the write.
        @(negedge clk);
        addr_a = 32'h5000_0020; data_a = 32'h9999_9999; we_a = 4'hF;
        #1;
        check("abort_hit_stall", {31'h0, stall_a}, 32'h1);
        @(negedge clk);
        check("sticky_err_b", {31'h0, err_b}, {31'h0, OOR_EN});
        rst_n = 1'b0;
        #1;
        check("abort_stall", {31'h0, stall_a}, 32'h0);
        check("abort_data", dout_a, 32'h0);
        check("abort_err_b", {31'h0, err_b}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1; addr_a = 32'h0; we_a = 4'h0;
        @(negedge clk);
        #1;
        check("post_rst_stall", {31'h0, stall_a}, 32'h0);
        acc_a(32'h5000_0020, 32'h0, 4'h0, 32'h5555_5555, "rd_after_abort");

        // Non-region access: no stall, no data_o change, no array change.
        @(negedge clk);
        addr_a = 32'h4000_0010; data_a = 32'h0; we_a = 4'hF;
        #1;
        check("other_region_stall", {31'h0, stall_a}, 32'h0);
        @(negedge clk);
        addr_a = 32'h0; we_a = 4'h0;
        #1;
        check("other_region_data", dout_a, 32'h5555_5555);
        acc_a(32'h5000_0010, 32'h0, 4'h0, 32'h1122_CC44, "rd_untouched");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wait_state_responder.md
WAIT_STATE_RESPONDER -- requirements
Module: wait_state_responder

Interface
REQ-001 SHALL have parameter REGION, default 4'h5; addr_i[31:28] value selecting this responder.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, range 0..15; stall cycles inserted per access.
REQ-003 SHALL have parameter DEPTH_LOG2, default 8; word-array depth is 2**DEPTH_LOG2 words of 32 bits.
REQ-004 SHALL have port clk_i, input, 1; the single clock, with all state updated on its rising edge.
REQ-005 SHALL have port rst_n_i, input, 1; asynchronous active-low reset.
REQ-006 SHALL have port addr_i, input, 32; CPU byte address.
REQ-007 SHALL have port data_i, input, 32; CPU write data, with byte lane n at bits [8n+7:8n].
REQ-008 SHALL have port data_w_i, input, 4; per-lane write enables, where 4'b0000 means read.
REQ-009 SHALL have port data_o, output, 32; registered read data.
REQ-010 SHALL have port stall_o, output, 1; CPU stall request.
REQ-011 SHALL have port err_o, output, 1; sticky out-of-range flag (see Configuration).

Function
REQ-012 SHALL define a hit as addr_i[31:28]==REGION while the FSM is in IDLE.
REQ-013 SHALL form the word index from addr_i[DEPTH_LOG2+1:2].
REQ-014 SHALL implement FSM states IDLE, WAIT and DONE.
REQ-015 With WAIT_CYCLES==0, a hit in cycle T SHALL perform the access at the edge ending T, keep the FSM in IDLE, and hold stall_o low.
REQ-016 With WAIT_CYCLES>0, a hit in cycle T SHALL assert stall_o combinationally in T, move to WAIT, and load the counter with WAIT_CYCLES-1.
REQ-017 In WAIT, stall_o SHALL be high; the counter SHALL decrement each cycle; at counter==0 the access SHALL execute at that edge and the FSM SHALL move to DONE.
REQ-018 stall_o SHALL therefore be high for exactly WAIT_CYCLES cycles, T..T+WAIT_CYCLES-1.
REQ-019 In DONE, stall_o SHALL be low and hits SHALL be ignored; the FSM SHALL return to IDLE after one cycle, preventing re-trigger on the held address.
REQ-020 The access SHALL use addr_i/data_i/data_w_i as sampled on the execution edge; the CPU holds these values stable while stalled.
REQ-021 On a write, only lanes with data_w_i[n]=1 SHALL be updated, and data_o SHALL be unchanged.
REQ-022 On a read, data_o SHALL be loaded with the addressed word at the execution edge and held until the next read executes.
REQ-023 A non-REGION address in IDLE SHALL cause no state change, no memory access, and no change to data_o.

Reset
REQ-024 rst_n_i low SHALL immediately force state IDLE, counter 0, stall_o 0, data_o 32'h0 and err_o 0.
REQ-025 Reset asserted mid-WAIT SHALL abort the access with no write, and release SHALL resume in IDLE.
REQ-026 Array contents SHALL NOT be reset.

Configuration
REQ-027 With macro WAIT_RESP_OOR_ERR_EN defined, an access whose addr_i[27:DEPTH_LOG2+2] is nonzero SHALL suppress the write, return 32'hDEADBEEF on a read, and set err_o, which clears only on reset.
REQ-028 Without WAIT_RESP_OOR_ERR_EN, those upper offset bits SHALL be ignored (aliasing), and err_o SHALL be tied to 0.
REQ-029 Stall timing SHALL be identical with and without WAIT_RESP_OOR_ERR_EN.

Structure
REQ-030 Package hfrv_resp_pkg SHALL hold the FSM state enum, the counter width constant (4) and the OOR read constant 32'hDEADBEEF.
REQ-031 Sub-module resp_mem SHALL implement the 4-byte-lane synchronous word array with per-lane write enables.
REQ-032 The FSM, wait counter, decode and err_o logic SHALL reside in wait_state_responder.

Verification
REQ-033 Write 0x5000_0010 with data 0x11223344 and data_w 4'hF at W=2, then read the same address -> stall high 2 cycles per access; data_o=0x11223344 in the DONE cycle.
REQ-034 Write 0x5000_0010 with data 0xAABBCCDD and data_w 4'b0010 over 0x11223344, then read -> data_o=0x1122CC44.
REQ-035 W=0: back-to-back reads of 0x5000_0000 and 0x5000_0004 -> stall_o never high; data_o updates on consecutive cycles.
REQ-036 Assert rst_n_i low during WAIT of a write to 0x5000_0020 -> stall_o 0 immediately; a later read of 0x5000_0020 returns the prior contents.
REQ-037 With WAIT_RESP_OOR_ERR_EN, read 0x5000_1000 at DEPTH_LOG2=8 -> data_o=0xDEADBEEF, err_o=1 until reset; without the macro -> same data as 0x5000_0000 and err_o=0.
REQ-038 Access 0x4000_0000 -> stall_o, data_o and the array are unchanged.
